// File: rtl/spi_cmd_sequencer.sv
// spi_cmd_sequencer: expands one high-level request (write, read, sample,
// status) into command/data byte groups for the SPI slave RAM/sampler,
// driving a byte-level SPI master. Polls the slave status register until a
// sample run completes.
// Optional build macro: SPI_SEQ_TIMEOUT_EN -- abort sample polling with
// rsp_err after POLL_MAX busy polls.
module spi_cmd_sequencer #(
  parameter int GAP_CYCLES    = 4,
  parameter int POLL_INTERVAL = 16,
  parameter int POLL_MAX      = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       busy,
  output logic       ssb,
  output logic       byte_start,
  output logic [7:0] byte_tx,
  input  logic       byte_done,
  input  logic [7:0] byte_rx
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_CMD, S_DAT, S_GAP, S_RDB, S_PWAIT, S_RESP
  } state_t;

  localparam logic [1:0] OP_WR  = 2'd0;
  localparam logic [1:0] OP_RD  = 2'd1;
  localparam logic [1:0] OP_SMP = 2'd2;
  localparam logic [1:0] OP_ST  = 2'd3;

  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] POLL_LAST = 16'(POLL_INTERVAL - 1);
  // Poll counter is 8 bits; it holds once it reaches the limit.
  localparam logic [7:0]  POLL_LIM  = 8'(POLL_MAX);

  state_t      state, state_n;
  logic [1:0]  op_q;
  logic [7:0]  addr_q, data_q;
  logic [1:0]  step_q;      // index of the group currently being sent
  logic [15:0] wait_cnt;    // shared by GAP and PWAIT
  logic        issued;      // byte_start already pulsed in this byte state
  logic [7:0]  stat_q;      // last received byte, drives rsp_data
  logic        err_q;
  logic        zero_q;      // zero-count sample: no traffic, error response
  logic [7:0]  poll_cnt;

  logic       accept, xfer_state, xfer_done, rd_grp;
  logic       gap_end, pwait_end, last_grp, poll_grp, poll_busy;
  logic       poll_lim_hit, timeout;
  logic [7:0] cmd_byte, dat_byte;

  assign accept     = req_valid && req_ready;
  assign xfer_state = (state == S_CMD) || (state == S_DAT) || (state == S_RDB);
  // Completion only counts once our own byte_start has gone out.
  assign xfer_done  = byte_done && issued && xfer_state;
  assign gap_end    = (state == S_GAP)   && (wait_cnt == GAP_LAST);
  assign pwait_end  = (state == S_PWAIT) && (wait_cnt == POLL_LAST);

  // Single-byte read groups: read step 2, status step 1, sample poll step 2.
  assign rd_grp = ((op_q == OP_RD)  && (step_q == 2'd2)) ||
                  ((op_q == OP_ST)  && (step_q == 2'd1)) ||
                  ((op_q == OP_SMP) && (step_q == 2'd2));

  assign last_grp = zero_q ||
                    ((op_q == OP_WR) && (step_q == 2'd1)) ||
                    ((op_q == OP_RD) && (step_q == 2'd2)) ||
                    ((op_q == OP_ST) && (step_q == 2'd1));

  assign poll_grp     = (op_q == OP_SMP) && (step_q == 2'd2);
  assign poll_busy    = poll_grp && stat_q[1];
  assign poll_lim_hit = (poll_cnt >= POLL_LIM);

`ifdef SPI_SEQ_TIMEOUT_EN
  assign timeout = poll_busy && poll_lim_hit;
`else
  assign timeout = 1'b0;
`endif

  // Command and data byte for the current op/step.
  always_comb begin
    cmd_byte = 8'h00;
    dat_byte = 8'h00;
    case (op_q)
      OP_WR: begin
        cmd_byte = (step_q == 2'd0) ? 8'h01 : 8'h02;
        dat_byte = (step_q == 2'd0) ? addr_q : data_q;
      end
      OP_RD: begin
        cmd_byte = (step_q == 2'd0) ? 8'h01 : 8'h03;
        dat_byte = (step_q == 2'd0) ? addr_q : 8'h00;
      end
      OP_SMP: begin
        cmd_byte = (step_q == 2'd0) ? 8'h04 : 8'h05;
        dat_byte = (step_q == 2'd0) ? data_q : 8'h00;
      end
      default: begin
        cmd_byte = 8'h05;
        dat_byte = 8'h00;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (accept)
                state_n = ((req_op == OP_SMP) && (req_data == 8'h00)) ? S_GAP : S_SETUP;
      S_SETUP: state_n = rd_grp ? S_RDB : S_CMD;
      S_CMD:   if (xfer_done) state_n = S_DAT;
      S_DAT:   if (xfer_done) state_n = S_GAP;
      S_RDB:   if (xfer_done) state_n = S_GAP;
      S_GAP: if (gap_end) begin
               if (poll_busy && !timeout)      state_n = S_PWAIT;
               else if (last_grp || poll_grp)  state_n = S_RESP;
               else                            state_n = S_SETUP;
             end
      S_PWAIT: if (pwait_end) state_n = S_SETUP;
      S_RESP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    ssb        = 1'b1;
    byte_start = 1'b0;
    byte_tx    = 8'h00;
    rsp_valid  = 1'b0;
    busy       = (state != S_IDLE);
    req_ready  = (state == S_IDLE) && !reset;
    case (state)
      S_SETUP: ssb = 1'b0;
      S_CMD: begin
        ssb        = 1'b0;
        byte_start = !issued;
        byte_tx    = cmd_byte;
      end
      S_DAT: begin
        ssb        = 1'b0;
        byte_start = !issued;
        byte_tx    = dat_byte;
      end
      S_RDB: begin
        ssb        = 1'b0;
        byte_start = !issued;
      end
      S_RESP:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign rsp_data = stat_q;
  assign rsp_err  = err_q;

  // Request capture, step/wait/poll counters and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= OP_WR;
      addr_q   <= 8'h00;
      data_q   <= 8'h00;
      step_q   <= 2'd0;
      wait_cnt <= 16'd0;
      issued   <= 1'b0;
      stat_q   <= 8'h00;
      err_q    <= 1'b0;
      zero_q   <= 1'b0;
      poll_cnt <= 8'h00;
    end else begin
      // byte_start is a single pulse per byte state visit.
      issued <= (state_n == state) ? (issued | byte_start) : 1'b0;

      if (accept) begin
        op_q     <= req_op;
        addr_q   <= req_addr;
        data_q   <= req_data;
        step_q   <= 2'd0;
        stat_q   <= 8'h00;
        poll_cnt <= 8'h00;
        zero_q   <= (req_op == OP_SMP) && (req_data == 8'h00);
        err_q    <= (req_op == OP_SMP) && (req_data == 8'h00);
      end else begin
        // Every re-entry to SETUP moves to the next group; PWAIT clears the
        // step so the poll loop restarts at the status command group.
        if ((state_n == S_SETUP) && (state != S_IDLE)) step_q <= step_q + 2'd1;
        else if (state_n == S_PWAIT)                   step_q <= 2'd0;

        if ((state == S_RDB) && xfer_done) begin
          stat_q <= byte_rx;
          if ((op_q == OP_SMP) && !poll_lim_hit) poll_cnt <= poll_cnt + 8'd1;
        end

        if (gap_end && timeout) err_q <= 1'b1;
      end

      // Zero-count sample spends a single cycle in GAP before responding.
      if (accept)
        wait_cnt <= ((req_op == OP_SMP) && (req_data == 8'h00)) ? GAP_LAST : 16'd0;
      else if (state_n != state)
        wait_cnt <= 16'd0;
      else if ((state == S_GAP) || (state == S_PWAIT))
        wait_cnt <= wait_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Bench for spi_cmd_sequencer: directed vector table plus hand sequences for
// reset, acceptance latency, zero-count sample and reset mid-operation.
module tb_spi_cmd_sequencer;
  localparam int GAP = 3;
  localparam int PI  = 5;
  localparam int PM  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = 2'd0;
  logic [7:0] req_addr = 8'h00, req_data = 8'h00;
  logic       rsp_valid, rsp_err, busy, ssb, byte_start;
  logic [7:0] rsp_data, byte_tx;
  logic       byte_done = 1'b0;
  logic [7:0] byte_rx = 8'h00;

  spi_cmd_sequencer #(.GAP_CYCLES(GAP), .POLL_INTERVAL(PI), .POLL_MAX(PM)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .ssb(ssb), .byte_start(byte_start), .byte_tx(byte_tx),
    .byte_done(byte_done), .byte_rx(byte_rx));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Byte-master model state. Each ssb-low window returns one scripted byte.
  logic [7:0]   tx_log[$];
  int           win = 0, run = 0, min_gap = 0, stab_err = 0, cnt = 0;
  logic [7:0]   cur_tx = 8'h00;
  logic         prev_ssb = 1'b1;
  logic [127:0] m_scr = '0;
  int           m_nscr = 0;
  logic [7:0]   m_fill = 8'h00;

  function automatic logic [7:0] scr_byte(int w);
    if (w >= 0 && w < m_nscr) return m_scr[(m_nscr-1-w)*8 +: 8];
    return m_fill;
  endfunction

  always @(negedge clk) begin
    byte_done = 1'b0;
    if (reset) begin
      cnt = 0;
      prev_ssb = 1'b1;
    end else begin
      if (prev_ssb && !ssb) begin
        if (win > 0 && run < min_gap) min_gap = run;
        win++;
        run = 0;
      end
      if (ssb && busy) run++;
      prev_ssb = ssb;
      if (byte_start) begin
        tx_log.push_back(byte_tx);
        cur_tx = byte_tx;
        cnt = 3;
      end else if (cnt > 0) begin
        if (byte_tx != cur_tx) stab_err++;
        cnt--;
        if (cnt == 0) begin
          byte_done = 1'b1;
          byte_rx = scr_byte(win - 1);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_clear(input logic [127:0] scr, input int nscr, input logic [7:0] fill);
    tx_log.delete();
    win = 0; run = 0; min_gap = 1000000; stab_err = 0;
    m_scr = scr; m_nscr = nscr; m_fill = fill;
  endtask

  task automatic wait_rsp(input string nm);
    int t = 0;
    while (!rsp_valid && t < 3000) begin step(); t++; end
    chk({nm, " rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
  endtask

  typedef struct {
    string        name;
    logic [1:0]   op;
    logic [7:0]   addr, data;
    logic [127:0] scr;
    int           nscr;
    logic [7:0]   fill;
    logic [127:0] tx;      // right-aligned, first byte most significant
    int           ntx;
    logic [7:0]   rdata;
    logic         err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(string name, logic [1:0] op, logic [7:0] addr,
      logic [7:0] data, logic [127:0] scr, int nscr, logic [7:0] fill,
      logic [127:0] tx, int ntx, logic [7:0] rdata, logic err);
    vec_t v;
    v.name = name; v.op = op; v.addr = addr; v.data = data;
    v.scr = scr; v.nscr = nscr; v.fill = fill;
    v.tx = tx; v.ntx = ntx; v.rdata = rdata; v.err = err;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int bad_idx;
    model_clear(v.scr, v.nscr, v.fill);
    req_valid = 1'b1; req_op = v.op; req_addr = v.addr; req_data = v.data;
    chk({v.name, " req_ready"}, {31'd0, req_ready}, 32'd1);
    step();
    // Fields are captured at acceptance; scramble them afterwards.
    req_valid = 1'b0; req_op = ~v.op; req_addr = ~v.addr; req_data = ~v.data;
    wait_rsp(v.name);
    chk({v.name, " rsp_data"}, {24'd0, rsp_data}, {24'd0, v.rdata});
    chk({v.name, " rsp_err"}, {31'd0, rsp_err}, {31'd0, v.err});
    step();
    chk({v.name, " rsp_pulse_ready"}, {30'd0, rsp_valid, req_ready}, 32'd1);
    chk({v.name, " tx_count"}, tx_log.size(), v.ntx);
    bad_idx = -1;
    for (int i = 0; i < v.ntx && i < tx_log.size(); i++)
      if (bad_idx < 0 && tx_log[i] !== v.tx[(v.ntx-1-i)*8 +: 8]) bad_idx = i;
    chk({v.name, " tx_first_bad_index"}, bad_idx, -1);
    chk({v.name, " tx_stable"}, stab_err, 0);
    if (v.ntx >= 3) chk({v.name, " min_gap"}, min_gap, GAP);
  endtask

  initial begin
    vecs.push_back(mkv("write_10_a5", 2'd0, 8'h10, 8'hA5, '0, 0, 8'h00,
                       {8'h01, 8'h10, 8'h02, 8'hA5}, 4, 8'h00, 1'b0));
    vecs.push_back(mkv("read_10", 2'd1, 8'h10, 8'h00, {8'h00, 8'h00, 8'h5A}, 3, 8'h00,
                       {8'h01, 8'h10, 8'h03, 8'h00, 8'h00}, 5, 8'h5A, 1'b0));
    vecs.push_back(mkv("status", 2'd3, 8'h00, 8'h00, {8'h00, 8'h06}, 2, 8'h00,
                       {8'h05, 8'h00, 8'h00}, 3, 8'h06, 1'b0));
    vecs.push_back(mkv("sample_3", 2'd2, 8'h00, 8'h03,
                       {8'h00, 8'h00, 8'h02, 8'h00, 8'h02, 8'h00, 8'h01}, 7, 8'h01,
                       {8'h04, 8'h03, 8'h05, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00,
                        8'h05, 8'h00, 8'h00}, 11, 8'h01, 1'b0));
    vecs.push_back(mkv("write_ff_00", 2'd0, 8'hFF, 8'h00, '0, 0, 8'h00,
                       {8'h01, 8'hFF, 8'h02, 8'h00}, 4, 8'h00, 1'b0));
    vecs.push_back(mkv("sample_1_ready", 2'd2, 8'h00, 8'h01, {8'h00, 8'h00, 8'h00}, 3, 8'h00,
                       {8'h04, 8'h01, 8'h05, 8'h00, 8'h00}, 5, 8'h00, 1'b0));
    vecs.push_back(mkv("sample_zero", 2'd2, 8'h00, 8'h00, '0, 0, 8'h00,
                       '0, 0, 8'h00, 1'b1));
`ifdef SPI_SEQ_TIMEOUT_EN
    vecs.push_back(mkv("sample_timeout", 2'd2, 8'h00, 8'h05, '0, 0, 8'h02,
                       {8'h04, 8'h05, 8'h05, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00,
                        8'h05, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00}, 14, 8'h02, 1'b1));
`endif

    // Reset state.
    repeat (3) step();
    chk("reset_outputs", {13'd0, ssb, byte_start, byte_tx, req_ready, rsp_valid,
                          rsp_data, rsp_err, busy},
        {13'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
    reset = 1'b0;
    step();
    chk("ready_after_reset", {31'd0, req_ready}, 32'd1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Acceptance latency and back-to-back data byte.
    begin
      int t;
      model_clear('0, 0, 8'h00);
      req_valid = 1'b1; req_op = 2'd0; req_addr = 8'h33; req_data = 8'h44;
      step();
      req_valid = 1'b0;
      chk("lat_setup", {28'd0, ssb, byte_start, busy, req_ready}, 32'b0010);
      step();
      chk("lat_first_start", {22'd0, ssb, byte_start, byte_tx}, {22'd0, 1'b0, 1'b1, 8'h01});
      t = 0;
      while (!byte_done && t < 50) begin step(); t++; end
      step();
      chk("data_start_next", {23'd0, byte_start, byte_tx}, {23'd0, 1'b1, 8'h33});
      wait_rsp("lat_write");
      step();
    end

    // Zero-count sample: response exactly two cycles after acceptance.
    model_clear('0, 0, 8'h00);
    req_valid = 1'b1; req_op = 2'd2; req_data = 8'h00;
    step();
    req_valid = 1'b0;
    chk("zero_n1", {29'd0, rsp_valid, ssb, busy}, 32'b011);
    step();
    chk("zero_n2", {30'd0, rsp_valid, rsp_err}, 32'b11);
    step();
    chk("zero_no_traffic", tx_log.size(), 0);

    // Reset between CMD and DAT of a write.
    begin
      int t, nrsp;
      model_clear('0, 0, 8'h00);
      req_valid = 1'b1; req_op = 2'd0; req_addr = 8'h55; req_data = 8'h66;
      step();
      req_valid = 1'b0;
      t = 0;
      while (!byte_done && t < 50) begin step(); t++; end
      step();
      reset = 1'b1;
      step();
      chk("midreset_outputs", {27'd0, ssb, busy, req_ready, byte_start, rsp_valid},
          32'b10000);
      reset = 1'b0;
      step();
      chk("midreset_ready", {31'd0, req_ready}, 32'd1);
      nrsp = 0;
      for (int i = 0; i < 30; i++) begin
        if (rsp_valid || !ssb) nrsp++;
        step();
      end
      chk("midreset_dropped", nrsp, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/spi_cmd_sequencer.md
# spi_cmd_sequencer

Master-side transaction sequencer for the SPI slave RAM/sampler block. Accepts one high-level request at a time (write byte, read byte, start sampling, read status) and expands it into the slave's command/data byte pairs on a byte-level SPI master interface. It controls chip select, inserts inter-pair gaps and polls the slave status register until sampling completes. Returns read data or status through a single-pulse response.

## Interface
Parameters:
- GAP_CYCLES, 4: idle `clk` cycles with `ssb` high between byte groups; minimum 1.
- POLL_INTERVAL, 16: idle cycles between consecutive status polls during a sample op.
- POLL_MAX, 255: maximum status polls before a timeout error; used only when `SPI_SEQ_TIMEOUT_EN` is defined.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a request is accepted on `req_valid && req_ready`.
- req_op  in  2  0=write, 1=read, 2=sample, 3=status.
- req_addr  in  8  RAM address (write/read only).
- req_data  in  8  write data (write) or sample count (sample).
- rsp_valid  out  1  one-cycle pulse at operation end.
- rsp_data  out  8  read byte (read), final status byte (sample/status), 0 for write.
- rsp_err  out  1  qualified by `rsp_valid`: zero-count sample or poll timeout.
- busy  out  1  high from acceptance through the `rsp_valid` cycle.
- ssb  out  1  slave select, active low.
- byte_start  out  1  one-cycle pulse: SPI master shifts `byte_tx`.
- byte_tx  out  8  byte to send; stable from `byte_start` until `byte_done`.
- byte_done  in  1  one-cycle pulse: byte complete, `byte_rx` valid.
- byte_rx  in  8  byte received during the last transfer.

## Operation
- Slave command codes: 0x01 write AR, 0x02 write DATAIN, 0x03 read DATA_OUT, 0x04 sample, 0x05 read status. A group is the command byte followed by the data byte, sent back to back with `ssb` low throughout.
- write: groups (0x01, addr), (0x02, data). `rsp_data`=0.
- read: groups (0x01, addr), (0x03, 0x00), then one read group made of the single byte 0x00. `rsp_data` is the `byte_rx` of that read byte.
- status: group (0x05, 0x00), then a read byte. `rsp_data` is the byte received; busy bit is `byte_rx[1]`.
- sample:
  - If `req_data`==0: no SPI traffic, `rsp_valid` with `rsp_err`=1 two cycles after acceptance.
  - Otherwise: group (0x04, count), then repeated status polls separated by POLL_INTERVAL idle cycles until a poll returns bit1=0.
  - `rsp_data` is the last status byte received.
- FSM states: IDLE, SETUP (`ssb` low, 1 cycle), CMD (pulse `byte_start` with the command byte, wait `byte_done`), DAT (same for the data byte), GAP (`ssb` high, GAP_CYCLES), RDB (read byte), PWAIT (poll interval), RESP (pulse `rsp_valid`, return to IDLE).
- A step counter (0..3) selects the next group for the op. Sample polling loops GAP → PWAIT → SETUP.
- `req_*` fields are captured on acceptance; later changes are ignored.
- A `byte_done` received outside CMD/DAT/RDB is ignored.

## Timing
- Reset values: `ssb`=1, `byte_start`=0, `byte_tx`=0, `req_ready`=0 during reset and 1 on the first cycle after, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `busy`=0.
- Acceptance at cycle N: `ssb` low at N+1 (SETUP), first `byte_start` at N+2.
- After `byte_done` of a command byte, the data byte's `byte_start` is issued the next cycle.
- After the final `byte_done` of a group, `ssb` rises the next cycle and stays high for exactly GAP_CYCLES cycles.
- `rsp_valid` follows the last GAP. `req_ready` reasserts the cycle after `rsp_valid`.
- Reset mid-operation: all outputs return to reset values on the next edge, `ssb` high immediately, and the in-flight op is dropped with no `rsp_valid`.
- Poll counter: 8-bit, saturating.

## Configuration
- `SPI_SEQ_TIMEOUT_EN` defined: a sample op that completes POLL_MAX polls, all still busy, ends with `rsp_err`=1 and `rsp_data` set to the last status byte.
- Not defined: polling continues indefinitely; `rsp_err` is set only for a zero-count sample.

## Test plan
- write addr 0x10 data 0xA5 -> byte_tx sequence 01,10,02,A5; `ssb` high ≥GAP_CYCLES between groups; rsp_valid with rsp_err=0.
- read addr 0x10, byte-master model returns 0x5A on the read byte -> tx sequence 01,10,03,00,00; rsp_data=0x5A.
- sample count 3, model returns status 0x02 for two polls then 0x01 -> tx 04,03 then three poll groups; rsp_data=0x01, rsp_err=0.
- sample count 0 -> no `byte_start`, `ssb` stays 1, rsp_valid with rsp_err=1 at acceptance+2.
- With `SPI_SEQ_TIMEOUT_EN`, POLL_MAX=4, status always 0x02 -> exactly 4 polls, then rsp_err=1, rsp_data=0x02.
- reset asserted between CMD and DAT of a write -> `ssb`=1 and busy=0 next cycle, no rsp_valid, req_ready=1 after reset deasserts.
